hit_referee: RTL
================

# hit_referee

Central hit-resolution block for the two-player fighting game. Each frame it compares both players' active hit boxes against the opponent's hurt boxes, decides hits and blocks, and drives back to each player FSM the `hitFlag`, `health` and `block` inputs that the player consumes. It also owns the round state (fight / KO) and reports the winner to the display and top-level game logic. One `clk` cycle is one game frame, the same as the player FSMs.

## Interface
- HEALTH_MAX, 5: health loaded at reset and at round start, at most 7.
- BLOCK_MAX, 3: block meter loaded at reset and at round start, at most 7.
- BLOCK_REGEN, 60: frames without being hit before one block point is regained, in the range 1..255.
- DMG_BASIC, 1: health lost on an unblocked basic hit.
- DMG_DIR, 2: health lost on an unblocked directional hit.
- clk  in  1  frame clock.
- rst  in  1  reset, asynchronous, active-high.
- new_round  in  1  single-cycle pulse; honoured only in R_KO.
- p1_state, p2_state  in  4  player current_state.
- pN_b_x1/x2/y1/y2  in  10 each  basic hit/hurt box of player N (N=1,2).
- pN_d_x1/x2/y1/y2  in  10 each  directional hit/hurt box of player N.
- pN_m_x1/x2/y1/y2  in  10 each  main hurtbox of player N.
- p1_hitflag, p2_hitflag  out  2  00 no hit, 01 hit by basic, 10 hit by directional.
- p1_health, p2_health  out  3  remaining health.
- p1_block, p2_block  out  3  remaining block meter.
- round_over  out  1  high while the block is in R_KO.
- winner  out  2  00 none, 01 P1 wins, 10 P2 wins, 11 draw.

## Operation
- Player state codes:
  - 0 idle, 1 move forward, 2 move backwards.
  - 3/4/5 basic attack start/end/pull.
  - 6/7/8 directional attack start/end/pull.
  - 9 hitstun, 10 blockstun.
- Active hitbox of an attacker:
  - basic box when its state is 4;
  - directional box when its state is 7;
  - none in any other state.
- Hurt region of a defender:
  - the main box is always part of it;
  - the basic box is added in states 3–5;
  - the directional box is added in states 6–8.
- Overlap test is inclusive and unsigned: a.x1<=b.x2 && b.x1<=a.x2 && a.y1<=b.y2 && b.y1<=a.y2.
- A candidate hit on player X requires all of:
  - the opponent's active hitbox overlaps any box of X's hurt region;
  - the opponent's `connected` flag is 0;
  - X's state is not 9 or 10 (no hit is registered during stun);
  - the round FSM is in R_FIGHT.
- `connected` flag, one per attacker:
  - set when that attacker's hit registers;
  - cleared in any cycle where that attacker's state is neither 4 nor 7;
  - result: at most one hit per attack.
- Blocked hit: X's state is 2 and X's block is greater than 0.
  - Block decrements by 1.
  - Health is unchanged.
  - Hitflag is still raised, so the player enters blockstun.
- Unblocked hit: health decreases by DMG_BASIC or DMG_DIR and saturates at 0. Block is unchanged.
- Trades: the two players are evaluated independently. Hits on P1 and P2 in the same cycle both register.
- Block regen, per player:
  - the counter runs in R_FIGHT while block < BLOCK_MAX;
  - it clears on any registered hit against that player;
  - when it reaches BLOCK_REGEN-1, block increments by 1 and the counter returns to 0;
  - the counter holds at 0 while block = BLOCK_MAX.
- Round FSM:
  - R_FIGHT → R_KO when either next health is 0. Winner is written on the same edge:
    - P2 at 0 only gives 01;
    - P1 at 0 only gives 10;
    - both at 0 gives 11.
  - R_KO: hitflags are forced to 00; health, block and winner are frozen; regen counters hold.
  - R_KO → R_FIGHT on new_round. Health is reloaded to HEALTH_MAX, block to BLOCK_MAX, winner to 00, and counters and connected flags are cleared.
  - new_round in R_FIGHT is ignored.

## Timing
- Reset values:
  - hitflags 00;
  - health HEALTH_MAX;
  - block BLOCK_MAX;
  - round_over 0, winner 00;
  - regen counters 0, connected flags 0;
  - FSM in R_FIGHT.
- Overlap sampled at edge N produces the following at N+1 (registered):
  - hitflag;
  - health/block update;
  - round_over/winner change.
- Hitflag is a single-cycle pulse and returns to 00 at N+2 unless a new hit registers.
- Repeat suppression: an attacker holding state 4 or 7 for several frames with continuous overlap produces exactly one pulse.
- Asynchronous rst in mid-round, including during R_KO, returns every output to its reset value immediately.

## Test plan
- P1 in state 4, basic box overlapping P2 main box for 3 frames, P2 idle, health 5 → one p2_hitflag=01 pulse one cycle after first overlap; p2_health 5→4; p2_block stays 3.
- P2 in state 7 hitting P1 while P1 is in state 2 with block 3 → p1_hitflag=10; p1_block 3→2; p1_health 5. Then 60 frames with no hit → p1_block back to 3.
- Same as above with P1 block 0 → p1_health 5→3 (DMG_DIR).
- Both players in state 4 with mutual overlap, both health 1 → both hitflags 01 on the same cycle; both health 0; round_over=1; winner=11. A later overlap produces no flags until new_round, after which health=5, block=3, winner=00.
- Hit attempted on a defender in state 9 or 10 → no hitflag and no health change.
- rst asserted mid-KO → outputs return at once to health 5, block 3, round_over 0, winner 00.

Source files
------------

// File: rtl/hit_referee.sv
// Per-frame hit resolution between two players: overlap tests, block/damage,
// block-meter regeneration and the fight/KO round state.
module hit_referee #(
  parameter int unsigned HEALTH_MAX  = 5,
  parameter int unsigned BLOCK_MAX   = 3,
  parameter int unsigned BLOCK_REGEN = 60,
  parameter int unsigned DMG_BASIC   = 1,
  parameter int unsigned DMG_DIR     = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       new_round,
  input  logic [3:0] p1_state,
  input  logic [3:0] p2_state,
  input  logic [9:0] p1_b_x1,
  input  logic [9:0] p1_b_x2,
  input  logic [9:0] p1_b_y1,
  input  logic [9:0] p1_b_y2,
  input  logic [9:0] p1_d_x1,
  input  logic [9:0] p1_d_x2,
  input  logic [9:0] p1_d_y1,
  input  logic [9:0] p1_d_y2,
  input  logic [9:0] p1_m_x1,
  input  logic [9:0] p1_m_x2,
  input  logic [9:0] p1_m_y1,
  input  logic [9:0] p1_m_y2,
  input  logic [9:0] p2_b_x1,
  input  logic [9:0] p2_b_x2,
  input  logic [9:0] p2_b_y1,
  input  logic [9:0] p2_b_y2,
  input  logic [9:0] p2_d_x1,
  input  logic [9:0] p2_d_x2,
  input  logic [9:0] p2_d_y1,
  input  logic [9:0] p2_d_y2,
  input  logic [9:0] p2_m_x1,
  input  logic [9:0] p2_m_x2,
  input  logic [9:0] p2_m_y1,
  input  logic [9:0] p2_m_y2,
  output logic [1:0] p1_hitflag,
  output logic [1:0] p2_hitflag,
  output logic [2:0] p1_health,
  output logic [2:0] p2_health,
  output logic [2:0] p1_block,
  output logic [2:0] p2_block,
  output logic       round_over,
  output logic [1:0] winner
);

  typedef struct packed {
    logic [9:0] x1;
    logic [9:0] x2;
    logic [9:0] y1;
    logic [9:0] y2;
  } box_t;

  typedef enum logic {R_FIGHT, R_KO} round_e;

  localparam logic [2:0] HP_INIT    = 3'(HEALTH_MAX);
  localparam logic [2:0] BLK_INIT   = 3'(BLOCK_MAX);
  localparam logic [7:0] REGEN_LAST = 8'(BLOCK_REGEN - 1);
  localparam logic [2:0] DMG_B      = 3'(DMG_BASIC);
  localparam logic [2:0] DMG_D      = 3'(DMG_DIR);

  function automatic logic overlap(input box_t a, input box_t b);
    return (a.x1 <= b.x2) && (b.x1 <= a.x2) && (a.y1 <= b.y2) && (b.y1 <= a.y2);
  endfunction

  box_t [1:0]       b_box, d_box, m_box, atk_box;
  logic [1:0][3:0]  st;
  logic [1:0]       atk_on, hurt, hit;
  logic [1:0][2:0]  dmg;

  round_e           round_q, round_d;
  logic [1:0][1:0]  hitflag_q, hitflag_d;
  logic [1:0][2:0]  health_q, health_d;
  logic [1:0][2:0]  block_q, block_d;
  logic [1:0][7:0]  regen_q, regen_d;
  logic [1:0]       conn_q, conn_d;
  logic [1:0]       winner_q, winner_d;

  assign b_box[0] = {p1_b_x1, p1_b_x2, p1_b_y1, p1_b_y2};
  assign d_box[0] = {p1_d_x1, p1_d_x2, p1_d_y1, p1_d_y2};
  assign m_box[0] = {p1_m_x1, p1_m_x2, p1_m_y1, p1_m_y2};
  assign b_box[1] = {p2_b_x1, p2_b_x2, p2_b_y1, p2_b_y2};
  assign d_box[1] = {p2_d_x1, p2_d_x2, p2_d_y1, p2_d_y2};
  assign m_box[1] = {p2_m_x1, p2_m_x2, p2_m_y1, p2_m_y2};
  assign st[0]    = p1_state;
  assign st[1]    = p2_state;

  always_comb begin
    atk_on    = '0;
    atk_box   = '0;
    hurt      = '0;
    hit       = '0;
    dmg       = '0;
    round_d   = round_q;
    hitflag_d = '0;
    health_d  = health_q;
    block_d   = block_q;
    regen_d   = regen_q;
    conn_d    = conn_q;
    winner_d  = winner_q;

    for (int unsigned i = 0; i < 2; i++) begin
      atk_on[i]  = (st[i] == 4'd4) || (st[i] == 4'd7);
      atk_box[i] = (st[i] == 4'd7) ? d_box[i] : b_box[i];
      dmg[i]     = (st[i] == 4'd7) ? DMG_D : DMG_B;
    end

    // Index i is the defender; 1-i is the attacker whose hitbox is tested.
    for (int unsigned i = 0; i < 2; i++) begin
      hurt[i] = overlap(atk_box[1-i], m_box[i])
              | ((st[i] >= 4'd3) && (st[i] <= 4'd5) && overlap(atk_box[1-i], b_box[i]))
              | ((st[i] >= 4'd6) && (st[i] <= 4'd8) && overlap(atk_box[1-i], d_box[i]));
      hit[i]  = (round_q == R_FIGHT) && atk_on[1-i] && !conn_q[1-i] && hurt[i]
              && (st[i] != 4'd9) && (st[i] != 4'd10);
    end

    for (int unsigned i = 0; i < 2; i++) begin
      if (!atk_on[i]) begin
        conn_d[i] = 1'b0;
      end else if (hit[1-i]) begin
        conn_d[i] = 1'b1;
      end
    end

    if (round_q == R_FIGHT) begin
      for (int unsigned i = 0; i < 2; i++) begin
        if (hit[i]) begin
          hitflag_d[i] = (st[1-i] == 4'd7) ? 2'b10 : 2'b01;
          regen_d[i]   = '0;
          if ((st[i] == 4'd2) && (block_q[i] != 3'd0)) begin
            block_d[i] = block_q[i] - 3'd1;
          end else begin
            health_d[i] = (health_q[i] > dmg[1-i]) ? health_q[i] - dmg[1-i] : '0;
          end
        end else if (block_q[i] < BLK_INIT) begin
          if (regen_q[i] == REGEN_LAST) begin
            block_d[i] = block_q[i] + 3'd1;
            regen_d[i] = '0;
          end else begin
            regen_d[i] = regen_q[i] + 8'd1;
          end
        end else begin
          regen_d[i] = '0;
        end
      end
      if ((health_d[0] == 3'd0) || (health_d[1] == 3'd0)) begin
        round_d  = R_KO;
        winner_d = {health_d[0] == 3'd0, health_d[1] == 3'd0};
      end
    end else if (new_round) begin
      round_d  = R_FIGHT;
      health_d = {HP_INIT, HP_INIT};
      block_d  = {BLK_INIT, BLK_INIT};
      regen_d  = '0;
      conn_d   = '0;
      winner_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      round_q   <= R_FIGHT;
      hitflag_q <= '0;
      health_q  <= {HP_INIT, HP_INIT};
      block_q   <= {BLK_INIT, BLK_INIT};
      regen_q   <= '0;
      conn_q    <= '0;
      winner_q  <= '0;
    end else begin
      round_q   <= round_d;
      hitflag_q <= hitflag_d;
      health_q  <= health_d;
      block_q   <= block_d;
      regen_q   <= regen_d;
      conn_q    <= conn_d;
      winner_q  <= winner_d;
    end
  end

  assign p1_hitflag = hitflag_q[0];
  assign p2_hitflag = hitflag_q[1];
  assign p1_health  = health_q[0];
  assign p2_health  = health_q[1];
  assign p1_block   = block_q[0];
  assign p2_block   = block_q[1];
  assign round_over = (round_q == R_KO);
  assign winner     = winner_q;

endmodule
